// File: rtl/bcd_seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner for a 0..1023 BCD value.
// The digits are latched once per full scan, so a displayed frame never mixes two values.
module bcd_seven_seg_scan #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       thousands,
    input  logic       blank_leading,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);
    localparam int            CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    hund_q, hund_d;
    logic          thou_q, thou_d;
    logic          blank_q, blank_d;
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_start_q, frame_start_d;

    logic          tick;
    logic          load;
    logic [3:0]    digit_val;
    logic          digit_blank;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        // Reload at the scan wrap so the new value starts with the ones slot.
        load          = (tick && idx_q == 2'd3) || pending_q;
        ones_d        = load ? ones          : ones_q;
        tens_d        = load ? tens          : tens_q;
        hund_d        = load ? hundreds      : hund_q;
        thou_d        = load ? thousands     : thou_q;
        blank_d       = load ? blank_leading : blank_q;
        pending_d     = 1'b0;
        frame_start_d = load;

        digit_val   = ones_q;
        digit_blank = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_val   = ones_q;
                digit_blank = 1'b0;
            end
            2'd1: begin
                digit_val   = tens_q;
                digit_blank = blank_q && !thou_q && hund_q == 4'd0 && tens_q == 4'd0;
            end
            2'd2: begin
                digit_val   = hund_q;
                digit_blank = blank_q && !thou_q && hund_q == 4'd0;
            end
            default: begin
                digit_val   = {3'b000, thou_q};
                digit_blank = blank_q && !thou_q;
            end
        endcase

        // Anode stays enabled on blanked digits; only the segments go dark.
        an_d  = ~(4'b0001 << idx_q);
        seg_d = digit_blank ? SEG_BLANK : glyph(digit_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
            hund_q        <= 4'd0;
            thou_q        <= 1'b0;
            blank_q       <= 1'b0;
            pending_q     <= 1'b1;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            hund_q        <= hund_d;
            thou_q        <= thou_d;
            blank_q       <= blank_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Scoreboard bench for bcd_seven_seg_scan: expected frames are queued as values are applied,
// and a monitor compares every displayed slot against them.
module tb_bcd_seven_seg_scan;
    localparam int PRESCALE = 4;

    typedef logic [3:0][6:0] frame_t;

    localparam logic [6:0] GLY [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ones = '0, tens = '0, hundreds = '0;
    logic       thousands = 1'b0, blank_leading = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    frame_t q[$];

    bcd_seven_seg_scan #(.PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset(reset), .ones(ones), .tens(tens), .hundreds(hundreds),
        .thousands(thousands), .blank_leading(blank_leading),
        .an(an), .seg(seg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected glyphs for the four slots: every digit above the most significant
    // nonzero one is dark when blanking is requested; the ones digit always shows.
    function automatic frame_t model(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h,
                                     input logic th, input logic bl);
        int     d[4];
        int     top;
        frame_t f;
        d[0] = int'(o);
        d[1] = int'(t);
        d[2] = int'(h);
        d[3] = int'(th);
        top = 0;
        for (int i = 0; i < 4; i++) if (d[i] != 0) top = i;
        for (int i = 0; i < 4; i++) begin
            if (bl && i > top)  f[i] = BLANK;
            else if (d[i] > 9)  f[i] = DASH;
            else                f[i] = GLY[d[i]];
        end
        return f;
    endfunction

    task automatic push_cur();
        q.push_back(model(ones, tens, hundreds, thousands, blank_leading));
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_start && n < 40);
        if (!frame_start) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_start: no frame_start within %0d cycles", n);
        end
    endtask

    task automatic send(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h,
                        input logic th, input logic bl, input int dly);
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        ones = o; tens = t; hundreds = h; thousands = th; blank_leading = bl;
        push_cur();
        wait_fs();
    endtask

    function automatic logic [3:0] rnd_nib();
        case ($urandom_range(0, 3))
            0:       return 4'd0;
            1:       return 4'($urandom_range(10, 15));
            default: return 4'($urandom_range(0, 9));
        endcase
    endfunction

    // Monitor: reset was sampled at the last edge -> idle outputs; otherwise each
    // sample after a frame_start belongs to slot (k-1)/4, or k/4 for the frame
    // loaded straight out of reset (its ones slot is one clock shorter).
    logic   rst_s = 1'b1;
    frame_t cur;
    int     k = 0;
    int     slot;
    bit     in_frame = 0, first = 0, after_rst = 0;
    logic [3:0] exp_an;

    always @(posedge clk) rst_s <= reset;

    always @(negedge clk) begin
        if (rst_s) begin
            chk("reset_state", {5'd0, an, seg}, {5'd0, 4'b1111, BLANK});
            chk("reset_fs", {15'd0, frame_start}, 16'd0);
            in_frame  = 0;
            after_rst = 1;
        end else begin
            if (in_frame) begin
                k++;
                slot = first ? k / 4 : (k - 1) / 4;
                if (slot > 3) begin
                    chk("frame_len", 16'(k), first ? 16'd15 : 16'd16);
                    in_frame = 0;
                end else begin
                    exp_an = ~(4'b0001 << slot);
                    chk("slot", {5'd0, an, seg}, {5'd0, exp_an, cur[slot]});
                    if (frame_start) chk("frame_len", 16'(k), first ? 16'd15 : 16'd16);
                end
            end
            if (frame_start) begin
                if (after_rst) chk("first_slot", {5'd0, an, seg}, {5'd0, 4'b1110, GLY[0]});
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: frame_start with no expected frame queued");
                    in_frame = 0;
                end else begin
                    cur      = q.pop_front();
                    in_frame = 1;
                end
                first     = after_rst;
                after_rst = 0;
                k         = 0;
            end else if (after_rst) begin
                chk("fs_after_reset", {15'd0, frame_start}, 16'd1);
                after_rst = 0;
            end
        end
    end

    initial begin
        ones = 4'd3; tens = 4'd2; hundreds = 4'd1; thousands = 1'b1; blank_leading = 1'b0;
        push_cur();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_fs();

        send(4'd2, 4'd4, 4'd0, 1'b0, 1'b1, 0);
        send(4'd2, 4'd4, 4'd0, 1'b0, 1'b0, 0);
        send(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 0);
        send(4'd7, 4'd0, 4'd0, 1'b1, 1'b1, 0);
        send(4'hC, 4'd0, 4'd0, 1'b0, 1'b1, 0);
        send(4'd3, 4'd2, 4'd1, 1'b0, 1'b0, 0);
        // Change arrives mid-frame (idx=1); the 123 frame must still finish.
        send(4'd6, 4'd5, 4'd4, 1'b0, 1'b0, 5);

        for (int i = 0; i < 24; i++) begin
            ones = rnd_nib(); tens = rnd_nib(); hundreds = rnd_nib();
            thousands = 1'($urandom_range(0, 1)); blank_leading = 1'($urandom_range(0, 1));
            send(rnd_nib(), rnd_nib(), rnd_nib(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end

        // Reset for one clock while idx=2; the new value reloads right after.
        ones = 4'd9; tens = 4'd0; hundreds = 4'd8; thousands = 1'b0; blank_leading = 1'b1;
        push_cur();
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_fs();

        send(4'd1, 4'd0, 4'd0, 1'b0, 1'b1, 3);
        push_cur();
        wait_fs();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
